axi_rd_arbiter: RTL and testbench

- Shares the single AXI read-address / read-data channel pair between the IF instruction-fetch port and the MEM data-load port.
- Both ports use the SRAM-like req/addr_ok/data_ok handshake.
- Sits inside the AXI bridge, between the pipeline's SRAM-like ports and the AXI master interface.
- Arbitrates AR issue, tracks outstanding reads per ID, blocks data reads that hit an in-flight write (RAW), and routes R beats back by rid.

---
 rtl/axi_rd_arbiter_pkg.sv | 20 ++
 rtl/axi_rd_arbiter_if.sv | 71 +++++++
 rtl/axi_rd_arbiter_outst_cnt.sv | 44 ++++
 rtl/axi_rd_arbiter.sv | 123 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter_pkg
// Description : Shared types and constants for the AXI read-channel arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_arbiter_pkg;

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_t;

    localparam logic [3:0] c_id_inst    = 4'd0;
    localparam logic [3:0] c_id_data    = 4'd1;
    localparam logic [1:0] c_burst_incr = 2'b01;
    localparam logic [7:0] c_len_single = 8'd0;

endpackage
`default_nettype wire

// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter_if
// Description : SRAM-like fetch/load ports, write-hazard info and AXI AR/R.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rd_arbiter_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic [1:0]  inst_size;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        wr_busy;
    logic [31:0] wr_addr;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // Arbiter side
    modport master (
        input  inst_req, inst_addr, inst_size,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_addr, data_size,
        output data_addr_ok, data_data_ok, data_rdata,
        input  wr_busy, wr_addr,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    // Pipeline ports plus AXI slave side
    modport slave (
        output inst_req, inst_addr, inst_size,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_addr, data_size,
        input  data_addr_ok, data_data_ok, data_rdata,
        output wr_busy, wr_addr,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter_outst_cnt.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter_outst_cnt
// Description : Saturating outstanding-read counter for one AXI ID.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter_outst_cnt #(
    parameter int MAX = 1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_inc,
    input  wire logic i_dec,
    output logic      o_full,
    output logic      o_empty
);

    localparam logic [1:0] c_max = 2'(MAX);

    logic [1:0] r_cnt;
    logic       w_dec_ok;
    logic       w_up;
    logic       w_dn;

    // A response with nothing outstanding is dropped rather than wrapping.
    assign w_dec_ok = i_dec & (r_cnt != 2'd0);
    assign w_up     = i_inc & ~w_dec_ok & (r_cnt < c_max);
    assign w_dn     = w_dec_ok & ~i_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else if (w_up) begin
            r_cnt <= r_cnt + 2'd1;
        end else if (w_dn) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end

    assign o_full  = (r_cnt >= c_max);
    assign o_empty = (r_cnt == 2'd0);

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Shares one AXI AR/R channel between fetch and load ports.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int         MAX_OUTST = 1,
    parameter logic [3:0] ID_INST   = c_id_inst,
    parameter logic [3:0] ID_DATA   = c_id_data
) (
    input  wire logic          clk,
    input  wire logic          reset,
    axi_rd_arbiter_if.master   bus
);

    ar_state_t   r_state;
    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic [3:0]  r_arid;
    logic [2:0]  r_arsize;

    logic w_inst_full, w_data_full;
    logic w_inst_empty, w_data_empty;
    logic w_raw_hit, w_inst_ok, w_data_ok_g;
    logic w_idle, w_grant_inst, w_grant_data;
    logic w_ar_hs, w_r_fire, w_r_inst, w_r_data;
    logic w_unused;

    // Load blocked while a write to the same word is still in flight.
    assign w_raw_hit    = bus.wr_busy & (bus.data_addr[31:2] == bus.wr_addr[31:2]);
    assign w_inst_ok    = bus.inst_req & ~w_inst_full;
    assign w_data_ok_g  = bus.data_req & ~w_data_full & ~w_raw_hit;

    assign w_idle       = (r_state == AR_IDLE) & ~reset;
    assign w_grant_data = w_idle & w_data_ok_g;
    assign w_grant_inst = w_idle & ~w_data_ok_g & w_inst_ok;

    assign bus.inst_addr_ok = w_grant_inst;
    assign bus.data_addr_ok = w_grant_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= AR_IDLE;
            r_arvalid <= 1'b0;
            r_araddr  <= 32'd0;
            r_arid    <= 4'd0;
            r_arsize  <= 3'd0;
        end else begin
            case (r_state)
                AR_IDLE: begin
                    if (w_grant_data) begin
                        r_araddr  <= bus.data_addr;
                        r_arsize  <= {1'b0, bus.data_size};
                        r_arid    <= ID_DATA;
                        r_arvalid <= 1'b1;
                        r_state   <= AR_BUSY;
                    end else if (w_grant_inst) begin
                        r_araddr  <= bus.inst_addr;
                        r_arsize  <= {1'b0, bus.inst_size};
                        r_arid    <= ID_INST;
                        r_arvalid <= 1'b1;
                        r_state   <= AR_BUSY;
                    end
                end
                AR_BUSY: begin
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= AR_IDLE;
                    end
                end
                default: r_state <= AR_IDLE;
            endcase
        end
    end

    assign w_ar_hs = r_arvalid & bus.arready;

    assign bus.arid    = r_arid;
    assign bus.araddr  = r_araddr;
    assign bus.arsize  = r_arsize;
    assign bus.arvalid = r_arvalid;
    assign bus.arlen   = c_len_single;
    assign bus.arburst = c_burst_incr;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;
    assign bus.rready  = 1'b1;

    // Single-beat reads: the last beat is the whole response, routed by rid.
    assign w_r_fire = bus.rvalid & bus.rlast & ~reset;
    assign w_r_inst = w_r_fire & (bus.rid == ID_INST);
    assign w_r_data = w_r_fire & (bus.rid == ID_DATA);

    assign bus.inst_data_ok = w_r_inst;
    assign bus.inst_rdata   = bus.rdata;
    assign bus.data_data_ok = w_r_data;
    assign bus.data_rdata   = bus.rdata;

    axi_rd_arbiter_outst_cnt #(.MAX(MAX_OUTST)) u_cnt_inst (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_ar_hs & (r_arid == ID_INST)),
        .i_dec   (w_r_inst),
        .o_full  (w_inst_full),
        .o_empty (w_inst_empty)
    );

    axi_rd_arbiter_outst_cnt #(.MAX(MAX_OUTST)) u_cnt_data (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_ar_hs & (r_arid == ID_DATA)),
        .i_dec   (w_r_data),
        .o_full  (w_data_full),
        .o_empty (w_data_empty)
    );

    assign w_unused = ^{bus.rresp, bus.wr_addr[1:0], w_inst_empty, w_data_empty};

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Directed scoreboard bench for the AXI read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    axi_rd_arbiter_if bus ();

    axi_rd_arbiter #(
        .MAX_OUTST (1),
        .ID_INST   (4'd0),
        .ID_DATA   (4'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_exp_t;

    typedef struct {
        int          port;   // 0 fetch, 1 load, 2 nobody
        logic [31:0] data;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the given port's addr_ok, records the AR it should produce.
    task automatic wait_addr_ok(input int port, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (port == 0 ? bus.inst_addr_ok : bus.data_addr_ok) begin
                got = 1'b1;
                chk("addr_ok_exclusive",
                    {31'd0, (port == 0 ? bus.data_addr_ok : bus.inst_addr_ok)}, 32'd0);
                if (port == 0)
                    ar_q.push_back('{4'd0, bus.inst_addr, {1'b0, bus.inst_size}});
                else
                    ar_q.push_back('{4'd1, bus.data_addr, {1'b0, bus.data_size}});
            end
            tick();
        end
        if (port == 0) bus.inst_req = 1'b0;
        else           bus.data_req = 1'b0;
        chk(port == 0 ? "inst_addr_ok_seen" : "data_addr_ok_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic expect_ar(input int budget);
        bit      got = 1'b0;
        ar_exp_t e;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.arvalid && bus.arready) begin
                got = 1'b1;
                chk("no_addr_ok_busy", {30'd0, bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
                chk("ar_expected", {31'd0, ar_q.size() != 0}, 32'd1);
                if (ar_q.size() != 0) begin
                    e = ar_q.pop_front();
                    chk("arid",   {28'd0, bus.arid},   {28'd0, e.id});
                    chk("araddr", bus.araddr,          e.addr);
                    chk("arsize", {29'd0, bus.arsize}, {29'd0, e.size});
                end
            end
            tick();
        end
        chk("ar_handshake_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic send_r(input logic [3:0] id, input logic [31:0] data, input int port);
        r_exp_t e;
        bus.rvalid = 1'b1;
        bus.rlast  = 1'b1;
        bus.rid    = id;
        bus.rdata  = data;
        r_q.push_back('{port, data});
        @(negedge clk);
        e = r_q.pop_front();
        chk("inst_data_ok", {31'd0, bus.inst_data_ok}, {31'd0, e.port == 0});
        chk("data_data_ok", {31'd0, bus.data_data_ok}, {31'd0, e.port == 1});
        if (e.port == 0) chk("inst_rdata", bus.inst_rdata, e.data);
        if (e.port == 1) chk("data_rdata", bus.data_rdata, e.data);
        tick();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.inst_req  = 1'b0;  bus.inst_addr = 32'd0; bus.inst_size = 2'd0;
        bus.data_req  = 1'b0;  bus.data_addr = 32'd0; bus.data_size = 2'd0;
        bus.wr_busy   = 1'b0;  bus.wr_addr   = 32'd0;
        bus.arready   = 1'b0;
        bus.rid       = 4'd0;  bus.rdata     = 32'd0; bus.rresp = 2'd0;
        bus.rlast     = 1'b0;  bus.rvalid    = 1'b0;

        // Reset state and fixed AR fields
        tick();
        tick();
        @(negedge clk);
        chk("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("rst_araddr",  bus.araddr, 32'd0);
        chk("rst_arid",    {28'd0, bus.arid}, 32'd0);
        chk("rst_arsize",  {29'd0, bus.arsize}, 32'd0);
        chk("rst_addr_ok", {30'd0, bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd0);
        chk("const_fields",
            {12'd0, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.rready},
            {12'd0, 8'd0, 2'b01, 2'b00, 4'b0000, 3'b000, 1'b1});
        tick();
        reset = 1'b0;

        // Single fetch
        bus.arready   = 1'b1;
        bus.inst_req  = 1'b1; bus.inst_addr = 32'h1C00_0000; bus.inst_size = 2'd2;
        wait_addr_ok(0, 1);
        expect_ar(1);
        send_r(4'd0, 32'h0280_0000, 0);

        // Contention: load wins, fetch follows on the next idle cycle
        bus.inst_req  = 1'b1; bus.inst_addr = 32'h1C00_0010; bus.inst_size = 2'd2;
        bus.data_req  = 1'b1; bus.data_addr = 32'h0000_1000; bus.data_size = 2'd2;
        wait_addr_ok(1, 1);
        expect_ar(1);
        wait_addr_ok(0, 1);
        expect_ar(1);
        send_r(4'd1, 32'hD000_1000, 1);
        send_r(4'd0, 32'h0000_0013, 0);

        // RAW block on the same word, fetch slips past
        bus.wr_busy   = 1'b1; bus.wr_addr   = 32'h0000_1004;
        bus.data_req  = 1'b1; bus.data_addr = 32'h0000_1006; bus.data_size = 2'd1;
        bus.inst_req  = 1'b1; bus.inst_addr = 32'h1C00_0020; bus.inst_size = 2'd2;
        wait_addr_ok(0, 1);
        expect_ar(1);
        @(negedge clk);
        chk("raw_blocked", {31'd0, bus.data_addr_ok}, 32'd0);
        tick();
        bus.wr_busy = 1'b0;
        wait_addr_ok(1, 1);
        expect_ar(1);
        send_r(4'd0, 32'hAAAA_0020, 0);
        send_r(4'd1, 32'hBBBB_1006, 1);

        // Outstanding limit on the fetch ID
        bus.inst_req  = 1'b1; bus.inst_addr = 32'h1C00_0030; bus.inst_size = 2'd2;
        wait_addr_ok(0, 1);
        expect_ar(1);
        bus.inst_req  = 1'b1; bus.inst_addr = 32'h1C00_0034;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("outst_full_block", {31'd0, bus.inst_addr_ok}, 32'd0);
            tick();
        end
        send_r(4'd0, 32'h1111_0030, 0);
        wait_addr_ok(0, 1);
        expect_ar(1);
        send_r(4'd0, 32'h2222_0034, 0);

        // AR backpressure: fields stable, no acceptance while busy
        bus.arready   = 1'b0;
        bus.data_req  = 1'b1; bus.data_addr = 32'h0000_2000; bus.data_size = 2'd0;
        wait_addr_ok(1, 1);
        bus.inst_req  = 1'b1; bus.inst_addr = 32'h1C00_0040;
        bus.data_req  = 1'b1; bus.data_addr = 32'h0000_3000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_arvalid", {31'd0, bus.arvalid}, 32'd1);
            chk("bp_araddr",  bus.araddr, 32'h0000_2000);
            chk("bp_arid",    {28'd0, bus.arid}, 32'd1);
            chk("bp_arsize",  {29'd0, bus.arsize}, 32'd0);
            chk("bp_addr_ok", {30'd0, bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
            tick();
        end
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        bus.arready  = 1'b1;
        expect_ar(1);
        bus.rresp = 2'b10;
        send_r(4'd5, 32'hBAD0_BAD0, 2);
        send_r(4'd1, 32'h3333_2000, 1);
        bus.rresp = 2'b00;

        // Reset while an AR is pending, with a load still outstanding
        bus.data_req  = 1'b1; bus.data_addr = 32'h0000_4000; bus.data_size = 2'd2;
        wait_addr_ok(1, 1);
        expect_ar(1);
        bus.arready   = 1'b0;
        bus.inst_req  = 1'b1; bus.inst_addr = 32'h1C00_0050;
        wait_addr_ok(0, 1);
        @(negedge clk);
        chk("pre_rst_arvalid", {31'd0, bus.arvalid}, 32'd1);
        tick();
        reset = 1'b1;
        ar_q.delete();
        tick();
        @(negedge clk);
        chk("mid_rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("mid_rst_data_ok", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd0);
        chk("mid_rst_addr_ok", {30'd0, bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
        tick();
        reset = 1'b0;
        bus.data_req  = 1'b1; bus.data_addr = 32'h0000_5000; bus.data_size = 2'd2;
        wait_addr_ok(1, 1);
        bus.arready   = 1'b1;
        expect_ar(1);
        send_r(4'd1, 32'h4444_5000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
